// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and default operand width shared by muldiv_ctrl and muldiv_datapath
package muldiv_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: iterative shift-add multiply (plus restoring divide when MULDIV_CTRL_DIV_EN is defined) with sign fix-up
module muldiv_datapath import muldiv_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               sgn,
`ifdef MULDIV_CTRL_DIV_EN
  input  logic               div,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result
);
  logic [WIDTH-1:0] hi, lo, m, a_mag, b_mag;
  logic [WIDTH:0] sum;
  logic neg_lo;
  assign a_mag = sgn && a[WIDTH-1] ? -a : a;
  assign b_mag = sgn && b[WIDTH-1] ? -b : b;
  assign sum = {1'b0, hi} + {1'b0, lo[0] ? m : {WIDTH{1'b0}}};
`ifdef MULDIV_CTRL_DIV_EN
  logic md, neg_hi, dz;
  logic [WIDTH:0] diff;
  assign dz = div && b == '0;
  assign diff = {hi, lo[WIDTH-1]} - {1'b0, m};
  always_ff @(posedge clk) begin
    if (rst) begin
      {hi, lo, m, md, neg_hi, neg_lo} <= '0;
    end else if (load) begin
      md <= div;
      hi <= dz ? a : '0;
      lo <= dz ? '1 : div ? a_mag : b_mag;
      m <= div ? b_mag : a_mag;
      neg_hi <= sgn && a[WIDTH-1] && !dz;
      neg_lo <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]) && !dz;
    end else if (step) begin
      hi <= md ? (diff[WIDTH] ? {hi[WIDTH-2:0], lo[WIDTH-1]} : diff[WIDTH-1:0]) : sum[WIDTH:1];
      lo <= md ? {lo[WIDTH-2:0], !diff[WIDTH]} : {sum[0], lo[WIDTH-1:1]};
    end
  end
  assign result = md ? {neg_hi ? -hi : hi, neg_lo ? -lo : lo} : neg_lo ? -{hi, lo} : {hi, lo};
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      {hi, lo, m, neg_lo} <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= b_mag;
      m <= a_mag;
      neg_lo <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      hi <= sum[WIDTH:1];
      lo <= {sum[0], lo[WIDTH-1:1]};
    end
  end
  assign result = neg_lo ? -{hi, lo} : {hi, lo};
`endif
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide controller; define MULDIV_CTRL_DIV_EN to include DIV/DIVU
module muldiv_ctrl import muldiv_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               mf_req,
  output logic [2*WIDTH-1:0] hilo_d,
  output logic [1:0]         hilo_write,
  output logic               busy,
  output logic               stall
);
  state_t state, state_n;
  logic [5:0] cnt;
  logic accept, is_mul, is_div, dz, load;
  logic [2*WIDTH-1:0] result;
  assign accept = start && state == IDLE;
  assign is_mul = op == OP_MULT || op == OP_MULTU;
`ifdef MULDIV_CTRL_DIV_EN
  assign is_div = op == OP_DIV || op == OP_DIVU;
`else
  assign is_div = 1'b0;
`endif
  assign dz = is_div && b == '0;
  assign load = accept && (is_mul || is_div);
  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk(clk),
    .rst(rst),
    .load(load),
    .step(state == BUSY),
    .sgn(op == OP_MULT || op == OP_DIV),
`ifdef MULDIV_CTRL_DIV_EN
    .div(is_div),
`endif
    .a(a),
    .b(b),
    .result(result)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= state == BUSY ? cnt + 6'd1 : '0;
    end
  end
  always_comb begin
    state_n = state == IDLE ? (load ? (dz ? DONE : BUSY) : IDLE)
            : state == BUSY ? (cnt == 6'(WIDTH - 1) ? DONE : BUSY) : IDLE;
    hilo_write = rst ? 2'b00 : state == DONE ? 2'b11 : {accept && op == OP_MTHI, accept && op == OP_MTLO};
    hilo_d = state == DONE ? result : {a, a};
    busy = state != IDLE;
    stall = busy && (mf_req || start);
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized and directed checks of muldiv_ctrl against an arithmetic reference model
module tb_muldiv_ctrl;
  logic clk = 0, rst = 1, start = 0, mf_req = 0;
  logic [2:0] op = 0;
  logic [31:0] a = 0, b = 0;
  logic [63:0] hilo_d;
  logic [1:0] hilo_write;
  logic busy, stall;
  int total = 0, bad = 0;
`ifdef MULDIV_CTRL_DIV_EN
  localparam bit DIV_EN = 1;
`else
  localparam bit DIV_EN = 0;
`endif

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .mf_req(mf_req),
    .hilo_d(hilo_d), .hilo_write(hilo_write), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    case (o)
      3'd0: return 64'(sx * sy);
      3'd1: return {32'b0, x} * {32'b0, y};
      3'd2: return y == 0 ? {x, 32'hFFFFFFFF} : {32'(sx % sy), 32'(sx / sy)};
      3'd3: return y == 0 ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      default: return 64'd0;
    endcase
  endfunction

  // reference model: one outstanding op, write scheduled by cycle number
  int cyc = 0, done_cyc = 0;
  bit active = 0, armed = 0;
  logic [63:0] res;
  always @(posedge clk) begin
    if (rst) active = 0;
    else if (active) begin
      if (cyc == done_cyc) active = 0;
    end else if (start && (op < 3'd2 || (DIV_EN && op < 3'd4))) begin
      active = 1;
      done_cyc = cyc + ((op > 3'd1 && b == 0) ? 1 : 33);
      res = model(op, a, b);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (!rst && armed) begin
      logic [1:0] wr_e;
      wr_e = active ? (cyc == done_cyc ? 2'b11 : 2'b00)
           : start ? (op == 3'd4 ? 2'b10 : op == 3'd5 ? 2'b01 : 2'b00) : 2'b00;
      chk("busy", 64'(busy), 64'(active));
      chk("stall", 64'(stall), 64'(active && (mf_req || start)));
      chk("hilo_write", 64'(hilo_write), 64'(wr_e));
      if (wr_e == 2'b11) chk("hilo_d", hilo_d, res);
      if (wr_e == 2'b10) chk("hilo_d_hi", 64'(hilo_d[63:32]), 64'(a));
      if (wr_e == 2'b01) chk("hilo_d_lo", 64'(hilo_d[31:0]), 64'(a));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1; op = o; a = x; b = y;
    tick();
    start = 0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_wr(input string nm, input int lat, input logic [63:0] v);
    int n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (hilo_write == 2'b11) break;
      tick();
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(lat));
    chk({nm, "_value"}, hilo_d, v);
    tick();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int sc, wr;
    tick(); tick();
    rst = 0;
    armed = 1;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_write", 64'(hilo_write), 64'd0);
    tick();

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_wr("multu_max", 33, 64'hFFFFFFFE_00000001);
    issue(3'd0, 32'hFFFFFFFD, 32'd5);
    wait_wr("mult_neg", 33, 64'hFFFFFFFF_FFFFFFF1);
`ifdef MULDIV_CTRL_DIV_EN
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_wr("div_neg", 33, 64'hFFFFFFFF_FFFFFFFD);
    issue(3'd3, 32'h1234, 32'd0);
    wait_wr("divu_zero", 1, 64'h00001234_FFFFFFFF);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_wr("div_ovf", 33, 64'h00000000_80000000);
`else
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    @(negedge clk);
    chk("div_disabled_busy", 64'(busy), 64'd0);
    tick();
`endif

    start = 1; op = 3'd5; a = 32'hCAFEF00D;
    @(negedge clk);
    chk("mtlo_write", 64'(hilo_write), 64'd1);
    chk("mtlo_data", 64'(hilo_d[31:0]), 64'hCAFEF00D);
    tick();
    start = 0;

    mf_req = 1;
    issue(3'd1, 32'd7, 32'd9);
    sc = 0;
    repeat (33) begin
      @(negedge clk);
      sc += int'(stall);
      tick();
    end
    @(negedge clk);
    chk("stall_cycles", 64'(sc), 64'd33);
    chk("stall_after", 64'(stall), 64'd0);
    mf_req = 0;
    tick();

    issue(3'd1, 32'd12345, 32'd678);
    repeat (9) tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    wr = 0;
    repeat (40) begin
      @(negedge clk);
      wr += int'(hilo_write != 2'b00);
      tick();
    end
    chk("abort_no_write", 64'(wr), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 4) == 0;
      op = 3'($urandom);
      a = pick();
      b = pick();
      mf_req = 1'($urandom);
      rst = ($urandom % 300) == 0;
      tick();
    end
    rst = 0;
    start = 0;
    repeat (40) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
